// File: rtl/dma_word_unpacker.sv
// dma_word_unpacker
//   Width converter and elastic buffer. It takes 32-bit DMA MM2S beats and
//   splits each one into two 16-bit words. Halves are kept or dropped
//   according to tkeep. The words are held in a first-word-fall-through FIFO
//   and emitted one per cycle under AXI-Stream backpressure.
//
//   Optional feature macro: DMA_UNPACK_STATS_EN
//     defined   -> words_out counts output handshakes (32-bit, wrapping)
//     undefined -> words_out is tied to zero and no counter is built
//
// Parameters
//   FIFO_DEPTH  FIFO entries (16-bit words). Must be a power of two, >= 4.
//   HIGH_FIRST  0: bits [15:0] are emitted first; 1: bits [31:16] are emitted first
//
// Ports
//   clk            stream clock
//   rst            asynchronous reset, active low
//   s_axis_*       32-bit input stream (tdata, tkeep, tlast, tvalid, tready)
//   m_axis_*       16-bit output stream (tdata, tlast, tvalid, tready)
//   flush          synchronous clear of all buffered state
//   fifo_level     number of words currently held
//   keep_err       sticky flag: a tkeep pair of 01 or 10 was accepted
//   words_out      output handshake count (zero without DMA_UNPACK_STATS_EN)
module dma_word_unpacker #(
  parameter int FIFO_DEPTH = 16,
  parameter int HIGH_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   s_axis_tdata,
  input  logic [3:0]                    s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [15:0]                   m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          keep_err,
  output logic [31:0]                   words_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam bit HF = (HIGH_FIRST != 0);

  // A tkeep pair marks a usable half only when both bytes are enabled.
  function automatic logic pair_ok(input logic [1:0] k);
    return (k == 2'b11);
  endfunction

  // A pair with exactly one byte enabled is malformed.
  function automatic logic pair_bad(input logic [1:0] k);
    return (k == 2'b01) || (k == 2'b10);
  endfunction

  logic            ready_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            err_q;
  logic [15:0]     mem_data [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];

  logic            lo_ok, hi_ok;
  logic            first_ok, second_ok;
  logic [15:0]     first_w, second_w;
  logic            accept;
  logic            beat_bad;
  logic            wr0, wr1;
  logic [15:0]     wr0_data;
  logic            wr0_last;
  logic [LW-1:0]   n_wr;
  logic            rd;

  // Input decode -> FIFO write
  always_comb begin
    lo_ok     = pair_ok(s_axis_tkeep[1:0]);
    hi_ok     = pair_ok(s_axis_tkeep[3:2]);
    first_ok  = HF ? hi_ok : lo_ok;
    second_ok = HF ? lo_ok : hi_ok;
    first_w   = HF ? s_axis_tdata[31:16] : s_axis_tdata[15:0];
    second_w  = HF ? s_axis_tdata[15:0]  : s_axis_tdata[31:16];
    beat_bad  = pair_bad(s_axis_tkeep[1:0]) | pair_bad(s_axis_tkeep[3:2]);

    // The space check needs room for two words, even when only one half is valid.
    // The ready path therefore never depends on the read in the same cycle.
    s_axis_tready = ready_q & ~flush & (level <= LW'(FIFO_DEPTH - 2));
    accept        = s_axis_tvalid & s_axis_tready;

    // Slot 0 gets the earlier valid half. Slot 1 is used only when both halves are valid.
    // tlast goes with whichever half is written last.
    wr0      = accept & (first_ok | second_ok);
    wr1      = accept & first_ok & second_ok;
    wr0_data = first_ok ? first_w : second_w;
    wr0_last = s_axis_tlast & ~(first_ok & second_ok);
    n_wr     = LW'(wr0) + LW'(wr1);

    // A handshake that coincides with a flush does not consume a word.
    rd = m_axis_tvalid & m_axis_tready & ~flush;
  end

  // Storage holds data only, so it needs no reset. Only written entries are
  // ever presented on the output.
  always_ff @(posedge clk) begin
    if (wr0) begin
      mem_data[wr_ptr] <= wr0_data;
      mem_last[wr_ptr] <= wr0_last;
    end
    if (wr1) begin
      mem_data[wr_ptr + PW'(1)] <= second_w;
      mem_last[wr_ptr + PW'(1)] <= s_axis_tlast;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        err_q  <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + PW'(n_wr);
        rd_ptr <= rd_ptr + PW'(rd);
        level  <= level + n_wr - LW'(rd);
        if (accept & beat_bad) err_q <= 1'b1;
      end
    end
  end

  // FIFO head -> output
  // tdata and tlast are gated by tvalid. This keeps them at zero while the
  // FIFO is empty and during reset, and it keeps unwritten storage off the port.
  always_comb begin
    m_axis_tvalid = (level != '0);
    m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : 16'd0;
    m_axis_tlast  = m_axis_tvalid & mem_last[rd_ptr];
  end

  assign fifo_level = level;
  assign keep_err   = err_q;

`ifdef DMA_UNPACK_STATS_EN
  logic [31:0] words_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_q <= 32'd0;
    end else if (flush) begin
      words_q <= 32'd0;
    end else if (m_axis_tvalid & m_axis_tready) begin
      words_q <= words_q + 32'd1;
    end
  end

  assign words_out = words_q;
`else
  assign words_out = 32'd0;
`endif

endmodule

// File: tb/tb_dma_word_unpacker.sv
// tb_dma_word_unpacker
//   Directed and randomized stimulus for dma_word_unpacker (FIFO_DEPTH=16,
//   HIGH_FIRST=0). A queue-based reference model predicts the stored words,
//   fifo_level, s_axis_tready, keep_err and words_out. The DUT outputs are
//   compared against the model on every falling edge. Directed sections also
//   compare the collected output words against literal values.
module tb_dma_word_unpacker;

  localparam int DEPTH = 16;
  localparam int HF    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  fifo_level;
  logic        keep_err;
  logic [31:0] words_out;

  dma_word_unpacker #(.FIFO_DEPTH(DEPTH), .HIGH_FIRST(HF)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .flush         (flush),
    .fifo_level    (fifo_level),
    .keep_err      (keep_err),
    .words_out     (words_out)
  );

  always #4 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [16:0] q[$];        // {tlast, word}, in output order
  logic [16:0] outlog[$];   // words actually handed out by the DUT
  bit          merr = 0;
  bit          mrq  = 0;    // ready becomes possible one edge after reset release
  logic [31:0] mcnt = '0;
  bit          acc_flag = 0;

  bit          a_v, b_v, acc_m, rd_m;
  logic [15:0] a_w, b_w;

  function automatic bit bad_pair(input logic [1:0] k);
    return (k == 2'b01) || (k == 2'b10);
  endfunction

  function automatic bit model_rdy();
    return mrq && !flush && (q.size() <= DEPTH - 2);
  endfunction

  function automatic logic [31:0] exp_words();
`ifdef DMA_UNPACK_STATS_EN
    return mcnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [16:0] lg(input int i);
    if (i < outlog.size()) return outlog[i];
    return 'x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      merr     = 0;
      mrq      = 0;
      mcnt     = '0;
      acc_flag = 0;
    end else begin
      acc_m    = model_rdy() && s_axis_tvalid;
      rd_m     = (q.size() != 0) && m_axis_tready && !flush;
      acc_flag = acc_m;
      if (flush) begin
        q.delete();
        merr = 0;
        mcnt = '0;
      end else begin
        if (rd_m) begin
          void'(q.pop_front());
          mcnt = mcnt + 32'd1;
        end
        if (acc_m) begin
          if (HF == 0) begin
            a_v = (s_axis_tkeep[1:0] == 2'b11); a_w = s_axis_tdata[15:0];
            b_v = (s_axis_tkeep[3:2] == 2'b11); b_w = s_axis_tdata[31:16];
          end else begin
            a_v = (s_axis_tkeep[3:2] == 2'b11); a_w = s_axis_tdata[31:16];
            b_v = (s_axis_tkeep[1:0] == 2'b11); b_w = s_axis_tdata[15:0];
          end
          if (a_v) q.push_back({s_axis_tlast && !b_v, a_w});
          if (b_v) q.push_back({s_axis_tlast, b_w});
          if (bad_pair(s_axis_tkeep[1:0]) || bad_pair(s_axis_tkeep[3:2])) merr = 1;
        end
      end
      mrq = 1;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    chk("s_tready",  s_axis_tready, model_rdy());
    chk("m_tvalid",  m_axis_tvalid, q.size() != 0);
    chk("level",     fifo_level, q.size());
    chk("keep_err",  keep_err, merr);
    chk("words_out", words_out, exp_words());
    if (q.size() != 0) chk("head", {m_axis_tlast, m_axis_tdata}, q[0]);
    if (rst && m_axis_tvalid && m_axis_tready && !flush)
      outlog.push_back({m_axis_tlast, m_axis_tdata});
  end

  // ---------------- stimulus ----------------
  bit rnd_on = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit got;
    got = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      cyc();
      got = acc_flag;
    end
    s_axis_tvalid = 1'b0;
    chk("beat_accept", got, 1);
  endtask

  initial begin
    forever begin
      cyc();
      if (rnd_on) m_axis_tready = ($urandom_range(0, 9) < 6);
    end
  end

  initial begin
    int idx;
    int gap;
    logic [3:0] k;

    // Reset release and a basic two-beat transfer
    repeat (3) cyc();
    rst = 1'b1;
    chk("tready_first_cycle", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    outlog.delete();
    send_beat(32'hBBBBAAAA, 4'hF, 1'b0);
    send_beat(32'hDDDDCCCC, 4'hF, 1'b1);
    repeat (6) cyc();
    chk("basic_count", outlog.size(), 4);
    chk("basic_w0", lg(0), 17'h0AAAA);
    chk("basic_w1", lg(1), 17'h0BBBB);
    chk("basic_w2", lg(2), 17'h0CCCC);
    chk("basic_w3", lg(3), 17'h1DDDD);

    // Single-half beats and the keep_err flag
    outlog.delete();
    send_beat(32'h1234ABCD, 4'h3, 1'b1);
    repeat (3) cyc();
    chk("keep3_count", outlog.size(), 1);
    chk("keep3_word", lg(0), 17'h1ABCD);
    chk("keep3_err", keep_err, 0);
    outlog.delete();
    send_beat(32'h1234ABCD, 4'h7, 1'b0);
    chk("keep7_err_rise", keep_err, 1);
    repeat (3) cyc();
    chk("keep7_count", outlog.size(), 1);
    chk("keep7_word", lg(0), 17'h0ABCD);
    chk("keep7_err_sticky", keep_err, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("keep_err_flushed", keep_err, 0);

    // Fill with the output stalled, then drain
    m_axis_tready = 1'b0;
    outlog.delete();
    idx = 0;
    s_axis_tkeep  = 4'hF;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = {16'h0101, 16'h0100};
    s_axis_tvalid = 1'b1;
    repeat (20) begin
      cyc();
      if (acc_flag) begin
        idx++;
        s_axis_tdata = {16'(256 + 2 * idx + 1), 16'(256 + 2 * idx)};
      end
    end
    s_axis_tvalid = 1'b0;
    chk("fill_beats", idx, 8);
    chk("fill_level", fifo_level, 16);
    chk("fill_tready", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    repeat (20) cyc();
    chk("fill_out_count", outlog.size(), 16);
    for (int j = 0; j < 16; j++) chk("fill_word", lg(j), {1'b0, 16'(256 + j)});

    // Flush with five words buffered and a beat offered
    m_axis_tready = 1'b0;
    send_beat(32'h22221111, 4'hF, 1'b0);
    send_beat(32'h44443333, 4'hF, 1'b0);
    send_beat(32'h00005555, 4'h3, 1'b0);
    chk("preflush_level", fifo_level, 5);
    s_axis_tdata  = 32'h77776666;
    s_axis_tkeep  = 4'hF;
    s_axis_tvalid = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("flush_level", fifo_level, 0);
    chk("flush_tvalid", m_axis_tvalid, 0);
    chk("flush_no_accept", acc_flag, 0);
    cyc();
    chk("flush_level_after", fifo_level, 0);

    // Reset pulse in the middle of a transfer
    send_beat(32'h9999CAFE, 4'h7, 1'b0);
    send_beat(32'h88887777, 4'hF, 1'b0);
    rst = 1'b0;
    #2;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_keep_err", keep_err, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_words_out", words_out, 0);
    cyc();
    cyc();
    rst = 1'b1;
    m_axis_tready = 1'b1;
    outlog.delete();
    send_beat(32'h22221111, 4'hF, 1'b0);
    send_beat(32'h44443333, 4'hF, 1'b1);
    repeat (6) cyc();
    chk("post_rst_count", outlog.size(), 4);
    chk("post_rst_w0", lg(0), 17'h01111);
    chk("post_rst_w1", lg(1), 17'h02222);
    chk("post_rst_w2", lg(2), 17'h03333);
    chk("post_rst_w3", lg(3), 17'h14444);

    // Randomized traffic against the model
    rnd_on = 1;
    for (int b = 0; b < 10000; b++) begin
      if ($urandom_range(0, 999) == 0) begin
        flush = 1'b1;
        cyc();
        flush = 1'b0;
      end
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      repeat (gap) cyc();
      case ($urandom_range(0, 15))
        0:       k = 4'h3;
        1:       k = 4'hC;
        2:       k = 4'h0;
        3:       k = 4'h7;
        4:       k = 4'hE;
        5:       k = 4'hB;
        default: k = 4'hF;
      endcase
      send_beat($urandom, k, ($urandom_range(0, 3) == 0));
    end
    rnd_on = 0;
    cyc();
    m_axis_tready = 1'b1;
    repeat (60) cyc();
    chk("drained_level", fifo_level, 0);
    chk("drained_model", q.size(), 0);
    chk("final_words_out", words_out, exp_words());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
